// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing types and constants for the decode path.
package hdc_pkg;
  localparam int HV_DIM  = 4096;
  localparam int HV_LOG2 = $clog2(HV_DIM);

  typedef logic [HV_DIM-1:0]           hv_t;
  typedef logic [$clog2(HV_DIM+1)-1:0] dist_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DIST,
    ST_DONE
  } unbind_state_e;
endpackage

// File: rtl/hv_popcount_chunk.sv
// hv_popcount_chunk: combinational population count of one CHUNK-bit slice.
// Latency: none (pure logic). Backpressure: not applicable.
module hv_popcount_chunk #(
  parameter int CHUNK = 256
) (
  input  logic [CHUNK-1:0]            i_bits,
  output logic [$clog2(CHUNK+1)-1:0]  o_count
);
  localparam int CNT_W = $clog2(CHUNK + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end
endmodule

// File: rtl/dec_unbinder.sv
// dec_unbinder: undoes k*SHIFT encoder right-rotations with a one-stage-per-cycle left barrel rotator; DEC_UNBINDER_DIST_EN adds a chunked Hamming distance to level_hv.
// Latency: LOG2 cycles accept->out_valid (plus HV_DIM/CHUNK with the distance option).
// Backpressure: one request in flight; in_ready low until the output handshake, DONE holds while out_ready is low.
module dec_unbinder
  import hdc_pkg::*;
#(
  parameter int HV_DIM = hdc_pkg::HV_DIM,
  parameter int SHIFT  = 1,
  parameter int POS_W  = 10
`ifdef DEC_UNBINDER_DIST_EN
  , parameter int CHUNK = 256
`endif
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [HV_DIM-1:0]           bound_hv,
  input  logic [POS_W-1:0]            pos,
`ifdef DEC_UNBINDER_DIST_EN
  input  logic [HV_DIM-1:0]           level_hv,
  output logic [$clog2(HV_DIM+1)-1:0] hamming_dist,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HV_DIM-1:0]           unbound_hv
);
  localparam int LOG2  = $clog2(HV_DIM);
  localparam int STG_W = $clog2(LOG2 + 1);

  unbind_state_e     r_state;
  unbind_state_e     w_state_nxt;
  logic [HV_DIM-1:0] r_work;
  logic [LOG2-1:0]   r_amt;
  logic [STG_W-1:0]  r_stage;
  logic [LOG2-1:0]   w_amt;
  logic [HV_DIM-1:0] w_rot [LOG2];
  logic              w_last_stage;
  logic              w_accept;

`ifdef DEC_UNBINDER_DIST_EN
  localparam int NCHUNK = HV_DIM / CHUNK;
  localparam int CH_W   = $clog2(NCHUNK + 1);
  localparam int PC_W   = $clog2(CHUNK + 1);
  localparam int DIST_W = $clog2(HV_DIM + 1);

  logic [HV_DIM-1:0] r_level;
  logic [CH_W-1:0]   r_chunk;
  logic [DIST_W-1:0] r_acc;
  logic [HV_DIM-1:0] w_diff;
  logic [CHUNK-1:0]  w_chunk_bits;
  logic [PC_W-1:0]   w_pc;
  logic              w_last_chunk;
`endif

  // Truncating both factors to LOG2 bits is the mod-HV_DIM wrap of pos*SHIFT.
  assign w_amt        = LOG2'(pos) * LOG2'(SHIFT);
  assign w_accept     = (r_state == ST_IDLE) && in_valid;
  assign w_last_stage = (r_stage == STG_W'(LOG2 - 1));
  assign unbound_hv   = r_work;

  for (genvar i = 0; i < LOG2; i++) begin : g_rot
    assign w_rot[i] = {r_work[HV_DIM-1-(1<<i):0], r_work[HV_DIM-1:HV_DIM-(1<<i)]};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_ROTATE;
      end
      ST_ROTATE: begin
        if (w_last_stage) begin
`ifdef DEC_UNBINDER_DIST_EN
          w_state_nxt = ST_DIST;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef DEC_UNBINDER_DIST_EN
      ST_DIST: begin
        if (w_last_chunk) w_state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Every stage takes a cycle even when its amt bit is clear, so latency is fixed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_work  <= '0;
      r_amt   <= '0;
      r_stage <= '0;
    end else if (w_accept) begin
      r_work  <= bound_hv;
      r_amt   <= w_amt;
      r_stage <= '0;
    end else if (r_state == ST_ROTATE) begin
      if (r_amt[r_stage]) r_work <= w_rot[r_stage];
      r_stage <= w_last_stage ? '0 : r_stage + 1'b1;
    end
  end

`ifdef DEC_UNBINDER_DIST_EN
  assign w_diff       = r_work ^ r_level;
  assign w_chunk_bits = w_diff[r_chunk*CHUNK +: CHUNK];
  assign w_last_chunk = (r_chunk == CH_W'(NCHUNK - 1));
  assign hamming_dist = r_acc;

  hv_popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_popcount (
    .i_bits  (w_chunk_bits),
    .o_count (w_pc)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_level <= '0;
      r_chunk <= '0;
      r_acc   <= '0;
    end else begin
      if (w_accept) r_level <= level_hv;
      if ((r_state == ST_ROTATE) && w_last_stage) begin
        r_acc   <= '0;
        r_chunk <= '0;
      end else if (r_state == ST_DIST) begin
        r_acc   <= r_acc + DIST_W'(w_pc);
        r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
      end
    end
  end
`endif
endmodule

// File: doc/dec_unbinder.md
# dec_unbinder

Decode-side inverse of the encoder's permutation binding. Accepts a bound hypervector plus its feature position `k` and undoes `k` applications of the encoder's right-rotate-by-`SHIFT`. The undo is a left rotation by `(k*SHIFT) mod HV_DIM`, performed as an iterative one-stage-per-cycle barrel rotator. Sits between the encoded-HV source and the level/class lookup logic in the decode path.

## Interface
- `HV_DIM`, 4096: hypervector width. Must be a power of two.
- `SHIFT`, 1: per-position rotate amount used by the encoder. Range 1 ≤ SHIFT < HV_DIM.
- `POS_W`, 10: width of the feature-position input.
- `CHUNK`, 256: popcount bits per cycle (distance option only). Must divide HV_DIM.
- `clk` in 1: clock, rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `bound_hv` in HV_DIM: bound (permuted) hypervector.
- `pos` in POS_W: feature position `k`.
- `level_hv` in HV_DIM: probe hypervector for distance. Present only with DEC_UNBINDER_DIST_EN.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `unbound_hv` out HV_DIM: recovered hypervector.
- `hamming_dist` out $clog2(HV_DIM+1): Hamming distance between `unbound_hv` and `level_hv`. Present only with DEC_UNBINDER_DIST_EN.

## Operation
- **States:** IDLE, ROTATE, DIST (option only), DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - Register `bound_hv` into the work register.
    - Compute `amt` = low LOG2 bits of `pos*SHIFT`. The full product width is POS_W+$clog2(SHIFT+1); truncation is the mod-HV_DIM wrap.
    - Register `level_hv` (option only).
    - Set stage=0 and go to ROTATE.
- **ROTATE**
  - At stage `i`, if `amt[i]`, the work register becomes its left rotation by `2^i`: `out[j]=in[(j-2^i) mod HV_DIM]`.
  - Stage increments by 1 each cycle.
  - After stage LOG2-1 the block goes to DIST (option) or DONE.
  - Exactly LOG2 = $clog2(HV_DIM) cycles, regardless of `amt`.
- **DIST (option only)**
  - Clear the accumulator on entry.
  - Each cycle, add popcount of chunk `c` of (work ^ registered level) into the accumulator.
  - Run HV_DIM/CHUNK cycles, then go to DONE.
- **DONE**
  - `out_valid`=1. `unbound_hv` and `hamming_dist` are held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. `in_ready`=0 in every other state.
- Identity checks:
  - `pos`=0 returns `bound_hv` unchanged.
  - `pos*SHIFT` ≡ 0 mod HV_DIM also returns `bound_hv` unchanged.
  - Applying the encoder's rotation `k` times and then this block with `pos`=`k` returns the original HV.

## Timing
- **Reset:** state=IDLE, `in_ready`=1, `out_valid`=0, `unbound_hv`='0, `hamming_dist`='0, stage/chunk counters=0.
- **Reset mid-operation:** immediate abort. In-flight data is discarded and the block does not resume.
- **Latency:** `out_valid` rises LOG2 cycles after the accept edge (12 at default). With the option it rises LOG2+HV_DIM/CHUNK cycles after (28 at default).
- **No overlap:** `in_ready` rises the cycle after the output handshake. Minimum initiation interval is latency+1.
- `unbound_hv` is driven directly from the work register. It is only meaningful while `out_valid`=1.
- `out_ready` held low stalls DONE indefinitely with no output change.

## Configuration
- **DEC_UNBINDER_DIST_EN defined:**
  - `level_hv` and `hamming_dist` ports exist.
  - The DIST state, level register, chunk counter and accumulator are present.
- **DEC_UNBINDER_DIST_EN undefined:**
  - Those ports and that logic are absent.
  - ROTATE goes straight to DONE.

## Structure
- **Shared package `hdc_pkg`:**
  - HV_DIM and HV_LOG2 constants.
  - `hv_t` typedef (logic [HV_DIM-1:0]).
  - `dist_t` typedef.
  - State enum `unbind_state_e`.
- **Sub-module `hv_popcount_chunk`:** combinational CHUNK-bit popcount, instantiated once.

## Test plan
- **Basic unbind:** `bound_hv`=1<<0, `pos`=1, SHIFT=1 → `unbound_hv`=1<<1; `out_valid` exactly 12 cycles after accept.
- **Wrap-around:**
  - `bound_hv`=1<<4095, `pos`=3 → `unbound_hv`=1<<2.
  - `pos`=0 → output equals input.
- **Round trip:** random HV, rotate right 37 times in the model, `pos`=37 → original HV recovered.
- **Backpressure:** `out_ready` low 20 cycles → `out_valid` and `unbound_hv` stable; `in_valid` pulses ignored with `in_ready`=0; after handshake `in_ready`=1 next cycle.
- **Reset mid-ROTATE:** assert `nrst`=0 at stage 5 → all outputs reset values; a new request afterwards completes correctly.
- **With option:** `level_hv` = expected unbound HV with 100 bits flipped → `hamming_dist`=100, `out_valid` at cycle 28; `level_hv`=~expected → 4096.
